temp_seg_display: RTL

- Downstream consumer of the DS18B20 reader's temp_data and sign outputs.
- Converts the 20-bit binary magnitude to BCD with a serial double-dabble state machine.
- Formats the result as a signed fixed-point reading, sign plus "ddd.dd" °C.
- Drives a 6-digit multiplexed common-anode 7-segment display.
- The upstream stage has no valid strobe, so conversion is triggered by any change on {sign, temp_data}.

---
 rtl/temp_seg_display.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/temp_seg_display.sv
// temp_seg_display: converts the DS18B20 reader's 20-bit magnitude (LSB = 0.001 C) plus sign
// into a signed "ddd.dd" reading on a 6-digit multiplexed common-anode 7-segment display.
// A serial double-dabble converter runs whenever {sign, temp_data} changes.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   temp_data  temperature magnitude, unsigned, LSB = 0.001 C
//   sign       1 = negative temperature
//   seg        active-low segments, seg[6:0] = g..a, seg[7] = dp
//   sel        active-low one-hot digit select, sel[5] = leftmost digit
//   overflow   high while the displayed value is saturated at 999.99
//   busy       high while a conversion is in progress
module temp_seg_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] temp_data,
    input  logic        sign,
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [20:0]     cap_q, cap_d;
    logic [19:0]     bin_q, bin_d;
    logic [27:0]     bcd_q, bcd_d;
    logic [4:0]      iter_q, iter_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic [5:0][7:0] disp_q, disp_d;
    logic [CntW-1:0] scan_q, scan_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      seg_q, seg_d;
    logic [5:0]      sel_q, sel_d;

    logic [27:0]     bcd_adj;
    logic [4:0][3:0] dig;      // dig[4] = hundreds .. dig[0] = hundredths
    logic            sat;
    logic            minus;

    // Conversion FSM and display formatting
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;

        bcd_adj = bcd_q;
        for (int i = 0; i < 7; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        // d0 (0.001 C) is dropped; a nonzero d6 saturates the reading
        sat = (bcd_q[27:24] != 4'd0);
        dig = sat ? {5{4'd9}} : bcd_q[23:4];
        minus = cap_q[20] && (dig != '0);

        unique case (state_q)
            StIdle: begin
                if ({sign, temp_data} != cap_q) begin
                    cap_d   = {sign, temp_data};
                    bin_d   = temp_data;
                    bcd_d   = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d  = {bcd_adj[26:0], bin_q[19]};
                bin_d  = {bin_q[18:0], 1'b0};
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd19) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ovf_d     = sat;
                disp_d[5] = minus ? 8'hBF : 8'hFF;
                disp_d[4] = (dig[4] == 4'd0) ? 8'hFF : seg_code(dig[4]);
                disp_d[3] = (dig[4] == 4'd0 && dig[3] == 4'd0) ? 8'hFF : seg_code(dig[3]);
                disp_d[2] = seg_code(dig[2]) & 8'h7F;
                disp_d[1] = seg_code(dig[1]);
                disp_d[0] = seg_code(dig[0]);
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Digit scan; sel and seg are both registered from the same index so they move together
    always_comb begin
        scan_d = scan_q + CntW'(1);
        idx_d  = idx_q;
        if (scan_q == CntW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        sel_d = ~(6'b000001 << idx_q);
        case (idx_q)
            3'd1:    seg_d = disp_q[1];
            3'd2:    seg_d = disp_q[2];
            3'd3:    seg_d = disp_q[3];
            3'd4:    seg_d = disp_q[4];
            3'd5:    seg_d = disp_q[5];
            default: seg_d = disp_q[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            cap_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0};
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            sel_q   <= 6'b111110;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign seg      = seg_q;
    assign sel      = sel_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;

endmodule
